count_monitor: RTL and testbench

//   Consumes the free-running WIDTH-bit count stream produced by the counter stage and checks

---
 rtl/count_monitor.sv | 193 +++++++++++++++++++
 tb/tb_count_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor
//   Sits downstream of a free-running counter. It checks that every sample is
//   the previous sample + 1 (mod 2^WIDTH), wrapping from all-ones to zero.
//   Each discontinuity is written into a small first-word-fall-through event
//   FIFO as {expected, actual}. The FIFO is drained over a valid/ready port.
//   A saturating error counter and a sticky overflow flag summarise activity.
//
// Parameters
//   WIDTH      width of the monitored count and of the event data fields
//   DEPTH      event FIFO entries (power of 2, >= 2)
//   ERR_CNT_W  width of err_count
//
// Ports
//   clk           single clock; all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   enable        monitoring enable; low returns the FSM to IDLE
//   clear         synchronous clear of err_count, overflow and the FIFO
//   data_in       count sample from the upstream counter, one per cycle
//   evt_valid     event FIFO non-empty
//   evt_ready     consumer accepts the head event
//   evt_expected  head event: expected value (prev+1), 0 when empty
//   evt_actual    head event: received value, 0 when empty
//   err_count     mismatches since reset/clear, saturating at all-ones
//   overflow      sticky: an event was dropped because the FIFO was full
//   locked        high while the FSM is in TRACK
// ---------------------------------------------------------------------------

// Event FIFO: first-word-fall-through. Head output is forced to 0 when empty.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. Otherwise the push is dropped and reported on 'dropped'.
module count_monitor_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic          dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              cnt;
    logic                     full;
    logic                     pop;
    logic                     wr_en;

    assign valid   = (cnt != '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign pop     = valid && ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr_en   = push && !flush && (!full || pop);
    assign dropped = push && !flush && full && !pop;
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // The storage needs no reset. Any entry that has not been written is
    // never presented, because head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end
endmodule

module count_monitor #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [WIDTH-1:0]     evt_expected,
    output logic [WIDTH-1:0]     evt_actual,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overflow,
    output logic                 locked
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] TRACK   = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] expected;
        logic [WIDTH-1:0] actual;
    } evt_t;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_val;
    logic             mismatch;
    logic             dropped;
    evt_t             push_evt;
    evt_t             head_evt;

    // Wraps naturally from all-ones to zero at WIDTH bits.
    assign exp_val  = prev + 1'b1;
    // No check while enable is low, even if the FSM is still in TRACK.
    assign mismatch = enable && (state == TRACK) && (data_in != exp_val);
    assign locked   = (state == TRACK);

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACQUIRE;
                ACQUIRE: state_nxt = TRACK;
                TRACK:   state_nxt = TRACK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // prev always follows data_in, mismatch or not. After a jump the next
    // expected value is therefore data_in+1, so one jump logs one event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            if (enable && (state == ACQUIRE || state == TRACK))
                prev <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
            if (dropped)                       overflow  <= 1'b1;
        end
    end

    assign push_evt = '{expected: exp_val, actual: data_in};

    // clear both flushes the FIFO and blocks a coincident push.
    count_monitor_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (mismatch),
        .push_data (push_evt),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .head      (head_evt),
        .dropped   (dropped)
    );

    assign evt_expected = head_evt.expected;
    assign evt_actual   = head_evt.actual;
endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int ECW   = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] data_in;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_expected;
    logic [WIDTH-1:0] evt_actual;
    logic [ECW-1:0]   err_count;
    logic             overflow;
    logic             locked;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2*WIDTH-1:0] sb[$];
    int                 m_state;   // 0 idle, 1 acquire, 2 track
    logic [WIDTH-1:0]   m_prev;
    int                 m_err;
    logic               m_ovf;

    always #5 clk = ~clk;

    count_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .data_in(data_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_expected(evt_expected), .evt_actual(evt_actual),
        .err_count(err_count), .overflow(overflow), .locked(locked)
    );

    task automatic model_reset();
        sb.delete();
        m_state = 0;
        m_prev  = '0;
        m_err   = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock cycle. Inputs are applied and checked at posedge+1.
    task automatic step(input logic [WIDTH-1:0] d, input logic en,
                        input logic rdy, input logic clr);
        logic             exp_v;
        logic             pop;
        logic             mism;
        logic [WIDTH-1:0] e;
        data_in = d; enable = en; evt_ready = rdy; clear = clr;
        #1;
        exp_v = (sb.size() != 0);
        checks++;
        if (evt_valid !== exp_v) begin
            errors++;
            $display("FAIL evt_valid: got %b want %b at %0t", evt_valid, exp_v, $time);
        end
        checks++;
        if (exp_v && {evt_expected, evt_actual} !== sb[0]) begin
            errors++;
            $display("FAIL evt_head: got %h/%h want %h/%h", evt_expected, evt_actual,
                     sb[0][2*WIDTH-1:WIDTH], sb[0][WIDTH-1:0]);
        end else if (!exp_v && {evt_expected, evt_actual} !== '0) begin
            errors++;
            $display("FAIL evt_empty_zero: got %h/%h want 0/0", evt_expected, evt_actual);
        end
        pop  = exp_v && rdy;
        e    = m_prev + 8'd1;
        mism = en && (m_state == 2) && (d != e);
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (clr) begin
            sb.delete();
            m_err = 0;
            m_ovf = 1'b0;
        end else if (mism) begin
            if (m_err < 255) m_err++;
            if (sb.size() < DEPTH) sb.push_back({e, d});
            else m_ovf = 1'b1;
        end
        if (!en) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else begin
            m_prev  = d;
            m_state = 2;
        end
        #1;
        checks++;
        if (locked !== (m_state == 2)) begin
            errors++;
            $display("FAIL locked: got %b want %b at %0t", locked, (m_state == 2), $time);
        end
        checks++;
        if (err_count !== ECW'(m_err)) begin
            errors++;
            $display("FAIL err_count: got %0d want %0d at %0t", err_count, m_err, $time);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow: got %b want %b at %0t", overflow, m_ovf, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; evt_ready = 1'b0; data_in = '0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_expected, evt_actual, err_count, overflow, locked} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b%h%h%h%b%b want all 0", evt_valid,
                     evt_expected, evt_actual, err_count, overflow, locked);
        end
    endtask

    task automatic test_track();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            step(WIDTH'(i), 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++; $display("FAIL locked_edge1: got %b want 0", locked);
                end
            end
            if (i >= 2) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++; $display("FAIL locked_edge3: got %b want 1 i=%0d", locked, i);
                end
            end
        end
        checks++;
        if (evt_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL clean_stream: got valid=%b err=%0d want 0/0", evt_valid, err_count);
        end
    endtask

    task automatic test_resync();
        logic [7:0] seq [7];
        seq = '{8'd4, 8'd5, 8'd6, 8'd9, 8'd10, 8'd11, 8'd12};
        do_reset();
        for (int i = 0; i < 7; i++) step(seq[i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(evt_valid === 1'b1 && evt_expected === 8'h07 && evt_actual === 8'h09 &&
              err_count === 8'd1 && sb.size() == 1)) begin
            errors++;
            $display("FAIL resync: got v=%b %h/%h err=%0d want 1 07/09 err=1", evt_valid,
                     evt_expected, evt_actual, err_count);
        end
        step(8'd13, 1'b1, 1'b1, 1'b0);
        step(8'd14, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) step(8'hFB + 8'(i), 1'b1, 1'b0, 1'b0);
        checks++;
        if (evt_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap: got valid=%b err=%0d want 0/0", evt_valid, err_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(8'd10, 1'b1, 1'b0, 1'b0);
        step(8'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 7; i++) step(8'(i * 10), 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(overflow === 1'b1 && err_count === 8'd6 && evt_expected === 8'd11 &&
              evt_actual === 8'd20)) begin
            errors++;
            $display("FAIL overflow_hold: got ovf=%b err=%0d head=%h/%h want 1 6 0b/14",
                     overflow, err_count, evt_expected, evt_actual);
        end
        for (int i = 1; i <= 5; i++) step(8'(70 + i), 1'b1, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b want 0", evt_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 302; i++) step(8'(2 * i), 1'b1, 1'b1, 1'b0);
        checks++;
        if (err_count !== 8'hFF) begin
            errors++; $display("FAIL saturate: got %h want ff", err_count);
        end
        step(8'h55, 1'b1, 1'b1, 1'b1);
        checks++;
        if (err_count !== 8'd0 || overflow !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: got err=%0d ovf=%b v=%b want 0", err_count, overflow, evt_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'd1, 1'b1, 1'b0, 1'b0);
        step(8'd1, 1'b1, 1'b0, 1'b0);
        step(8'd5, 1'b1, 1'b0, 1'b0);
        step(8'd9, 1'b1, 1'b0, 1'b0);
        step(8'd20, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_expected, evt_actual, err_count, overflow, locked} !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b %h/%h err=%0d ovf=%b lk=%b want all 0",
                     evt_valid, evt_expected, evt_actual, err_count, overflow, locked);
        end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step(8'(100 + i), 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b0, 1'b0, 1'b0);
        step(8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_track();
        test_resync();
        test_wrap();
        test_overflow();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
